// File: rtl/seq_player.sv
// Genius color-sequence playback: fetches each stored color, lights its LED, blanks, then pulses done.
// Optional all-LED flash before done when SEQ_PLAYER_FLASH_ALL_EN is defined.
module seq_player #(
   parameter int COLOR_CODEFY_W = 2,
   parameter int ADDR_WIDTH     = 5,
   parameter int ON_CYC_SLOW    = 8,
   parameter int ON_CYC_FAST    = 4,
   parameter int GAP_CYC        = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      play_start,
   input  logic                      abort,
   input  logic [ADDR_WIDTH:0]       seq_len,
   input  logic                      speed,
   output logic                      mem_rd_en,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   input  logic [COLOR_CODEFY_W-1:0] mem_rdata,
   output logic                      led_green,
   output logic                      led_red,
   output logic                      led_blue,
   output logic                      led_yellow,
   output logic                      busy,
   output logic                      done
);

   localparam int ON_MAX = (ON_CYC_SLOW > ON_CYC_FAST) ? ON_CYC_SLOW : ON_CYC_FAST;
   localparam int C_MAX  = (ON_MAX > GAP_CYC) ? ON_MAX : GAP_CYC;
   localparam int CNT_W  = $clog2(C_MAX + 1);

   localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_SHOW,
      S_GAP,
      S_FINISH
`ifdef SEQ_PLAYER_FLASH_ALL_EN
      , S_FLASH
`endif
   } state_t;

   state_t                state_q;
   logic [3:0]            leds_q;
   logic                  rd_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic                  speed_q;
   logic                  busy_q;
   logic                  done_q;
   logic [CNT_W-1:0]      cnt_q;

   logic [CNT_W-1:0]      on_last;
   logic                  last_step;

   assign on_last   = speed_q ? CNT_W'(ON_CYC_FAST - 1) : CNT_W'(ON_CYC_SLOW - 1);
   assign last_step = ({1'b0, idx_q} == (len_q - LEN_ONE));

   // one-hot {yellow, blue, red, green}
   function automatic logic [3:0] dec(input logic [1:0] c);
      dec = 4'b0001 << c;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         leds_q  <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         speed_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (abort && state_q != S_IDLE) begin
         state_q <= S_IDLE;
         leds_q  <= '0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (play_start) begin
                  speed_q <= speed;
                  busy_q  <= 1'b1;
                  if (seq_len != '0) begin
                     len_q   <= (seq_len > FULL_LEN) ? FULL_LEN : seq_len;
                     idx_q   <= '0;
                     addr_q  <= '0;
                     rd_q    <= 1'b1;
                     state_q <= S_FETCH;
                  end else begin
`ifdef SEQ_PLAYER_FLASH_ALL_EN
                     leds_q  <= 4'hF;
                     cnt_q   <= speed ? CNT_W'(ON_CYC_FAST - 1)
                                      : CNT_W'(ON_CYC_SLOW - 1);
                     state_q <= S_FLASH;
`else
                     done_q  <= 1'b1;
                     state_q <= S_FINISH;
`endif
                  end
               end
            end
            S_FETCH: begin
               rd_q    <= 1'b0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               leds_q  <= dec(mem_rdata[1:0]);
               cnt_q   <= on_last;
               state_q <= S_SHOW;
            end
            S_SHOW: begin
               if (cnt_q == '0) begin
                  leds_q  <= '0;
                  cnt_q   <= CNT_W'(GAP_CYC - 1);
                  state_q <= S_GAP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_GAP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (last_step) begin
`ifdef SEQ_PLAYER_FLASH_ALL_EN
                  leds_q  <= 4'hF;
                  cnt_q   <= on_last;
                  state_q <= S_FLASH;
`else
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
`endif
               end else begin
                  idx_q   <= idx_q + ADDR_WIDTH'(1);
                  addr_q  <= idx_q + ADDR_WIDTH'(1);
                  rd_q    <= 1'b1;
                  state_q <= S_FETCH;
               end
            end
`ifdef SEQ_PLAYER_FLASH_ALL_EN
            S_FLASH: begin
               if (cnt_q == '0) begin
                  leds_q  <= '0;
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
`endif
            S_FINISH: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_rd_en  = rd_q;
   assign mem_addr   = addr_q;
   assign led_green  = leds_q[0];
   assign led_red    = leds_q[1];
   assign led_blue   = leds_q[2];
   assign led_yellow = leds_q[3];
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
